// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multicycle RV32I control FSM
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctl_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // Per-state Moore decode; fetch gates ir_write/pc_write with mem_ready
    typedef struct packed {
        logic        fetch;
        logic        pc_upd;
        logic        branch;
        logic        adr_src;
        logic        mem_write;
        logic        reg_write;
        logic        decode;
        result_src_e result_src;
        src_a_e      src_a;
        src_b_e      src_b;
        alu_op_e     alu_op;
    } ctl_t;

    function automatic imm_src_e imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction fields in, datapath controls out
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal;

    modport master (
        input  op, funct3, funct7_5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_write, illegal
    );

    modport slave (
        output op, funct3, funct7_5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_write, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - maps alu_op plus funct fields to alu_control
module alu_decoder
    import multicycle_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type (op5=1) can request sub; addi with bit30 set stays add
                    3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM; CTRL_PERF_EN adds cycles/instret counters
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]        instret,
    output logic [31:0]        cycles
`endif
);

    state_t state;
    state_t nxt;
    ctl_t   ctl;

    function automatic ctl_t state_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.src_b      = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.decode = 1'b1;
                c.src_a  = SRCA_OLDPC;
                c.src_b  = SRCB_IMM;
            end
            S_MEMADR: begin
                c.src_a = SRCA_RS1;
                c.src_b = SRCB_IMM;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.src_a  = SRCA_RS1;
                c.alu_op = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.src_a  = SRCA_RS1;
                c.src_b  = SRCB_IMM;
                c.alu_op = ALUOP_FUNCT;
            end
            S_ALUWB:    c.reg_write = 1'b1;
            S_BEQ: begin
                c.src_a  = SRCA_RS1;
                c.alu_op = ALUOP_SUB;
                c.branch = 1'b1;
            end
            S_JAL: begin
                c.src_a  = SRCA_OLDPC;
                c.src_b  = SRCB_FOUR;
                c.pc_upd = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:    if (bus.mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_R:         nxt = S_EXECUTER;
                    OP_I:         nxt = S_EXECUTEI;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_JAL:       nxt = S_JAL;
                    default:      nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) nxt = S_MEMWB;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) nxt = S_FETCH;
            S_EXECUTER, S_EXECUTEI: nxt = S_ALUWB;
            S_ALUWB:    nxt = S_FETCH;
            S_BEQ:      nxt = S_FETCH;
            S_JAL:      nxt = S_ALUWB;
            default:    nxt = S_FETCH;
        endcase
    end

    // Controls are registered alongside the state so they come straight off flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RESET_STATE;
            ctl   <= state_ctl(RESET_STATE);
        end else begin
            state <= nxt;
            ctl   <= state_ctl(nxt);
        end
    end

    assign bus.ir_write   = rst_n & ctl.fetch & bus.mem_ready;
    assign bus.pc_write   = rst_n & ((ctl.fetch & bus.mem_ready) | ctl.pc_upd |
                                     (ctl.branch & bus.zero));
    assign bus.mem_write  = rst_n & ctl.mem_write;
    assign bus.reg_write  = rst_n & ctl.reg_write;
    assign bus.illegal    = rst_n & ctl.decode & ~is_legal(bus.op);
    assign bus.adr_src    = ctl.adr_src;
    assign bus.result_src = ctl.result_src;
    assign bus.alu_src_a  = ctl.src_a;
    assign bus.alu_src_b  = ctl.src_b;
    assign bus.imm_src    = imm_sel(bus.op);

    alu_decoder u_alu_decoder (
        .alu_op      (ctl.alu_op),
        .funct3      (bus.funct3),
        .op5         (bus.op[5]),
        .funct7_5    (bus.funct7_5),
        .alu_control (bus.alu_control)
    );

`ifdef CTRL_PERF_EN
    logic retire;
    assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                    ((state == S_MEMWRITE) && bus.mem_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycles  <= '0;
            instret <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (retire) instret <= instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized and directed checks of multicycle_ctrl against a plan-queue model
module tb_multicycle_ctrl;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
    localparam int P_XR = 6, P_XI = 7, P_AWB = 8, P_BQ = 9, P_JL = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
`ifdef CTRL_PERF_EN
    logic [31:0] instret, cycles;
`endif

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CTRL_PERF_EN
        ,
        .instret (instret),
        .cycles  (cycles)
`endif
    );

    int          phase = P_F;
    int          plan[$];
    bit          model_valid = 1'b0;
    logic [31:0] exp_cycles = 0;
    logic [31:0] exp_instret = 0;

    function automatic logic [2:0] funct_alu(logic [6:0] o, logic [2:0] f3, logic f75);
        if (f3 == 3'd0) return (o[5] && f75) ? 3'd1 : 3'd0;
        if (f3 == 3'd2) return 3'd5;
        if (f3 == 3'd6) return 3'd3;
        if (f3 == 3'd7) return 3'd2;
        return 3'd0;
    endfunction

    // {pc_write, adr_src, mem_write, ir_write, result_src, a, b, alu, imm, reg_write, illegal}
    function automatic logic [16:0] exp_out(int ph, logic [6:0] o, logic [2:0] f3,
                                            logic f75, logic z, logic mr);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, a, b, imm;
        logic [2:0] alu;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 0; a = 0; b = 0; alu = 0;
        imm = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
        case (ph)
            P_F:   begin b = 2; rs = 2; irw = mr; pcw = mr; end
            P_D:   begin a = 1; b = 1;
                         ill = !(o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL); end
            P_MA:  begin a = 2; b = 1; end
            P_MR:  adr = 1;
            P_MWB: begin rs = 1; rw = 1; end
            P_MW:  begin adr = 1; mw = 1; end
            P_XR:  begin a = 2; alu = funct_alu(o, f3, f75); end
            P_XI:  begin a = 2; b = 1; alu = funct_alu(o, f3, f75); end
            P_AWB: rw = 1;
            P_BQ:  begin a = 2; alu = 3'd1; pcw = z; end
            P_JL:  begin a = 1; b = 2; pcw = 1; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, rs, a, b, alu, imm, rw, ill};
    endfunction

    // Model: decode builds the list of remaining steps; memory steps stall on mem_ready
    always @(posedge clk) begin
        if (!rst_n) begin
            phase = P_F;
            plan.delete();
            model_valid = 1'b1;
            exp_cycles = 0;
            exp_instret = 0;
        end else if (model_valid) begin
            exp_cycles = exp_cycles + 1;
            if (phase == P_F) begin
                if (bus.mem_ready) phase = P_D;
            end else if (phase == P_D) begin
                plan.delete();
                case (bus.op)
                    LW: begin plan.push_back(P_MA); plan.push_back(P_MR); plan.push_back(P_MWB); end
                    SW: begin plan.push_back(P_MA); plan.push_back(P_MW); end
                    RT: begin plan.push_back(P_XR); plan.push_back(P_AWB); end
                    IT: begin plan.push_back(P_XI); plan.push_back(P_AWB); end
                    BQ: plan.push_back(P_BQ);
                    JL: begin plan.push_back(P_JL); plan.push_back(P_AWB); end
                    default: ;
                endcase
                phase = (plan.size() == 0) ? P_F : plan.pop_front();
            end else if ((phase == P_MR || phase == P_MW) && !bus.mem_ready) begin
                phase = phase;
            end else if (plan.size() == 0) begin
                phase = P_F;
                exp_instret = exp_instret + 1;
            end else begin
                phase = plan.pop_front();
            end
        end
    end

    logic [16:0] got_v, exp_v;
    assign got_v = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.imm_src,
                    bus.reg_write, bus.illegal};

    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if ({bus.pc_write, bus.mem_write, bus.ir_write, bus.reg_write, bus.illegal} !== 5'b0) begin
                errors++;
                $display("FAIL reset_enables got=%b exp=00000",
                         {bus.pc_write, bus.mem_write, bus.ir_write, bus.reg_write, bus.illegal});
            end
        end else if (model_valid) begin
            exp_v = exp_out(phase, bus.op, bus.funct3, bus.funct7_5, bus.zero, bus.mem_ready);
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL ctrl phase=%0d op=%b got=%h exp=%h", phase, bus.op, got_v, exp_v);
            end
`ifdef CTRL_PERF_EN
            checks++;
            if (cycles !== exp_cycles || instret !== exp_instret) begin
                errors++;
                $display("FAIL perf got=%0d/%0d exp=%0d/%0d", cycles, instret, exp_cycles, exp_instret);
            end
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    int n_cyc, n_mw, n_rw, n_pcw, n_ill;
    logic [2:0] alu_seen;
    logic [1:0] rs_rw, imm_seen;

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                             input logic z, input int stalls);
        int left;
        left = stalls;
        n_cyc = 0; n_mw = 0; n_rw = 0; n_pcw = 0; n_ill = 0;
        alu_seen = 3'bx; rs_rw = 2'bx; imm_seen = 2'bx;
        bus.op = o; bus.funct3 = f3; bus.funct7_5 = f75; bus.zero = z;
        for (int k = 0; k < 40; k++) begin
            bus.mem_ready = 1'b1;
            if ((phase == P_MW || phase == P_MR) && left > 0) begin
                bus.mem_ready = 1'b0;
                left--;
            end
            @(negedge clk);
            n_cyc++;
            n_mw  += int'(bus.mem_write);
            n_rw  += int'(bus.reg_write);
            n_pcw += int'(bus.pc_write);
            n_ill += int'(bus.illegal);
            if (bus.reg_write) rs_rw = bus.result_src;
            if (phase == P_XR || phase == P_XI || phase == P_BQ) alu_seen = bus.alu_control;
            if (phase == P_D) imm_seen = bus.imm_src;
            @(posedge clk); #1;
            if (phase == P_F) return;
        end
        check("instr_timeout", 32'(n_cyc), 32'd0);
    endtask

    logic [6:0] ops [6] = '{LW, SW, RT, IT, BQ, JL};

    initial begin
        bus.op = IT; bus.funct3 = 0; bus.funct7_5 = 0; bus.zero = 0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ir_write", 32'(bus.ir_write), 32'd1);
        check("rst_pc_write", 32'(bus.pc_write), 32'd1);
        check("rst_alu_src_b", 32'(bus.alu_src_b), 32'd2);
        @(posedge clk); #1;
        for (int k = 0; k < 10 && phase != P_F; k++) begin @(posedge clk); #1; end

        run_instr(LW, 3'd0, 1'b0, 1'b0, 0);
        check("lw_cycles", n_cyc, 5);
        check("lw_reg_write", n_rw, 1);
        check("lw_result_src", 32'(rs_rw), 32'd1);
        check("lw_imm", 32'(imm_seen), 32'd0);

        run_instr(SW, 3'd2, 1'b0, 1'b0, 3);
        check("sw_cycles", n_cyc, 7);
        check("sw_mem_write", n_mw, 4);
        check("sw_imm", 32'(imm_seen), 32'd1);

        run_instr(BQ, 3'd0, 1'b0, 1'b1, 0);
        check("beq_t_cycles", n_cyc, 3);
        check("beq_t_pc_write", n_pcw, 2);
        check("beq_t_alu", 32'(alu_seen), 32'd1);
        check("beq_t_imm", 32'(imm_seen), 32'd2);
        run_instr(BQ, 3'd0, 1'b0, 1'b0, 0);
        check("beq_nt_pc_write", n_pcw, 1);
        check("beq_nt_imm", 32'(imm_seen), 32'd2);

        run_instr(RT, 3'd0, 1'b1, 1'b0, 0);
        check("sub_cycles", n_cyc, 4);
        check("sub_alu", 32'(alu_seen), 32'd1);
        run_instr(IT, 3'd0, 1'b1, 1'b0, 0);
        check("addi_alu", 32'(alu_seen), 32'd0);
        run_instr(RT, 3'd6, 1'b0, 1'b0, 0);
        check("or_alu", 32'(alu_seen), 32'd3);

        run_instr(JL, 3'd0, 1'b0, 1'b0, 0);
        check("jal_cycles", n_cyc, 4);
        check("jal_pc_write", n_pcw, 2);
        check("jal_imm", 32'(imm_seen), 32'd3);

`ifdef CTRL_PERF_EN
        begin
            logic [31:0] c0, i0;
            c0 = cycles; i0 = instret;
            run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0);
            check("ill_instret", instret, i0);
            check("ill_cycles", cycles, c0 + 32'd2);
        end
`else
        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0);
`endif
        check("ill_pulse", n_ill, 1);
        check("ill_cycles_n", n_cyc, 2);

        for (int c = 0; c < 3000; c++) begin
            if (phase == P_F)
                bus.op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            bus.funct3    = 3'($urandom);
            bus.funct7_5  = 1'($urandom);
            bus.zero      = 1'($urandom);
            bus.mem_ready = ($urandom_range(0, 9) < 7);
            rst_n         = ($urandom_range(0, 199) != 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle build of the RV32I core.
- Sequences the shared ALU, memory port, register file and the immediate extender over several cycles per instruction.
- Drives the extender select: I=00, S=01, B=10, J=11.
- Sits between the instruction register fields and the datapath muxes/write enables; all outputs are Moore-style, decoded from state, plus the branch `zero` term and memory handshake gating.

Parameters:
- RESET_STATE, S_FETCH, initial FSM state after reset (encoding from package).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- op  in  7  instruction opcode (instr[6:0])
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address mux: 0=PC, 1=ALUOut
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction/oldPC register enable
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 data
- alu_src_b  out  2  00=rs2 data, 01=ImmExt, 10=constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  extender select, decoded combinationally from op
- reg_write  out  1  register file write enable
- illegal  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- One clock; reset is synchronous and active-low.
- While rst_n=0: pc_write, mem_write, ir_write, reg_write and illegal are forced to 0. On the edge with rst_n=0, state <= FETCH. Reset mid-instruction abandons it; no partial writes after that edge.
- States and their outputs (unlisted enables 0, unlisted selects 00):
  - FETCH: adr_src=0, a=00, b=10, alu_op=add, result_src=10. ir_write=pc_update=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
  - DECODE: a=01, b=01, add (branch target into ALUOut). Next state by op:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - else illegal=1, -> FETCH
  - MEMADR: a=10, b=01, add. -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Waits for mem_ready, then -> MEMWB.
  - MEMWB: result_src=01, reg_write=1. -> FETCH.
  - MEMWRITE: adr_src=1, mem_write=1, held until mem_ready. -> FETCH on mem_ready.
  - EXECUTER: a=10, b=00, alu_op=funct. -> ALUWB.
  - EXECUTEI: a=10, b=01, alu_op=funct. -> ALUWB.
  - ALUWB: result_src=00, reg_write=1. -> FETCH.
  - BEQ: a=10, b=00, sub, result_src=00, branch=1. -> FETCH.
  - JAL: a=01, b=10, add, result_src=00, pc_update=1. -> ALUWB.
- pc_write = pc_update | (branch & zero).
- ALU decode:
  - alu_op add -> 000; sub -> 001.
  - funct: funct3 000 gives 001 if op[5]&funct7_5, else 000. 010 -> 101, 110 -> 011, 111 -> 010, others -> 000.
- imm_src by op:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else 00
- Cycle counts with mem_ready tied 1: lw 5, sw 4, R/I 4, beq 3, jal 4.

Optional Feature:
- Macro CTRL_PERF_EN.
- Defined: adds outputs instret[31:0] and cycles[31:0].
  - cycles increments every cycle rst_n=1.
  - instret increments on every transition into FETCH from a completing state (MEMWB, MEMWRITE done, ALUWB, BEQ), excluding illegal.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; remaining behaviour is identical.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - imm_src, alu_control, result_src and src-mux encodings, shared with the extender and ALU
- Sub-module alu_decoder (alu_op, funct3, op5, funct7_5 -> alu_control), purely combinational.

Test Plan:
- Reset: rst_n=0 for 2 cycles with mem_ready=1 -> all enables 0; after release, first cycle in FETCH shows ir_write=1, pc_write=1, alu_src_b=10.
- lw (op=0000011, mem_ready=1) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 only in MEMWB with result_src=01; imm_src=00.
- sw with mem_ready low 3 cycles in MEMWRITE -> mem_write held 1 for 4 cycles, then FETCH; imm_src=01.
- beq: zero=1 -> pc_write=1 in BEQ, alu_control=001. zero=0 -> pc_write=0. imm_src=10 both cases.
- R-type sub (funct3=000, funct7_5=1) -> alu_control=001 in EXECUTER. Same opcode as I-type 0010011 with funct7_5=1 -> 000.
- op=1111111 -> illegal pulses 1 cycle in DECODE, next state FETCH. With CTRL_PERF_EN, instret unchanged while cycles keeps incrementing.
